mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequences the memory stage for a multi-cycle data memory. It watches the memory control and data leaving the EX/MEM pipeline register and drives a request/done handshake to data memory. While an access is outstanding it drops the shared pipeline enable, freezing the EX/MEM register and all upstream stages. It then releases exactly one advance cycle with the load data valid. It also detects unaligned accesses and memory timeouts and latches a sticky error.

## Interface
- TIMEOUT, 64: max cycles in BUSY before giving up; 2..255
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- read_mem  in  1  load in EX/MEM (registered output of EX/MEM)
- write_mem  in  1  store in EX/MEM
- addr  in  16  ALU result from EX/MEM (byte address)
- wdata  in  16  store data (data_2) from EX/MEM
- mem_en  out  1  request to data memory, held until mem_done
- mem_wr  out  1  1 = write, valid while mem_en
- mem_addr  out  16  registered address, valid while mem_en
- mem_wdata  out  16  registered store data, valid while mem_en
- mem_done  in  1  memory completion pulse, meaningful only while mem_en=1
- mem_rdata  in  16  load data, valid with mem_done
- pipe_en  out  1  enable for EX/MEM and all upstream pipeline registers
- rdata_out  out  16  captured load data to MEM/WB
- rdata_valid  out  1  one-cycle strobe, load data on rdata_out
- err  out  1  sticky fault (unaligned or timeout)

## Operation
- States: IDLE, BUSY, DONE, ERR.
- IDLE, no read_mem/write_mem:
  - pipe_en=1, mem_en=0; stay IDLE.
- IDLE, op present, addr[0]=0:
  - pipe_en=0 combinationally this cycle.
  - Register addr, wdata, mem_wr=write_mem; clear counter; go BUSY.
- IDLE, op present, addr[0]=1: pipe_en=0; go ERR.
- IDLE, read_mem and write_mem both 1: treat as unaligned fault; go ERR.
- BUSY:
  - mem_en=1, pipe_en=0; counter increments each cycle.
  - mem_done=1: capture mem_rdata into rdata_out (loads only); go DONE.
  - Else, counter = TIMEOUT-1: go ERR.
  - mem_done and timeout in the same cycle: mem_done wins.
- DONE:
  - pipe_en=1 for exactly this cycle; mem_en=0.
  - rdata_valid=1 iff the access was a load.
  - Go IDLE unconditionally; the next EX/MEM contents are evaluated in IDLE on the following cycle.
- ERR:
  - err=1, pipe_en=0, mem_en=0.
  - Held until reset.
- rdata_out holds its last captured value otherwise; store accesses leave it unchanged.
- Counter is 8 bits and saturates; it never wraps.

## Timing
- Reset (asynchronous assert, synchronous-release assumption):
  - State IDLE.
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata_out=0, rdata_valid=0, err=0, counter=0.
  - pipe_en=1 (IDLE with no op).
- Op visible in EX/MEM at cycle t:
  - BUSY from t+1, with mem_en high from t+1.
  - mem_done earliest at t+1.
  - mem_done at t+k gives DONE at t+k+1, which is the pipeline advance edge.
  - Total stall k+1 cycles; minimum memory op occupancy 3 cycles (t, t+1, t+2).
- Non-memory instructions: zero added latency.
- Back-to-back memory ops: the second is seen in IDLE one cycle after DONE.
- mem_done outside BUSY: ignored.
- Reset asserted mid-BUSY: mem_en drops immediately (asynchronously); the access is abandoned.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE, BUSY, DONE, ERR)
  - DATA_W=16, ADDR_W=16, CNT_W=8
- One sub-module `mem_timeout_cnt`:
  - saturating up-counter with clear, enable and terminal compare against TIMEOUT-1.
  - The FSM and capture registers stay in the top.

## Test plan
- Load, addr=0x0010, mem_done 2 cycles after mem_en rises, mem_rdata=0xBEEF: pipe_en low 3 cycles, then one DONE cycle with rdata_valid=1, rdata_out=0xBEEF.
- Store, addr=0x0020, wdata=0x1234, mem_done 1 cycle after mem_en: mem_wr=1, mem_addr=0x0020, mem_wdata=0x1234, rdata_valid never 1, rdata_out unchanged.
- Load, addr=0x0011: pipe_en=0 that cycle, err=1 next cycle, mem_en never asserted, err persists 20 cycles.
- TIMEOUT=4, mem_done never asserted: mem_en high 4 cycles, then err=1, mem_en=0, pipe_en=0.
- TIMEOUT=4, mem_done exactly on the 4th BUSY cycle: DONE, err stays 0.
- Reset pulled low on the 2nd BUSY cycle: mem_en=0 immediately; after release state IDLE, pipe_en=1, all outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the memory-stage access controller.
package mem_ctrl_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // A halfword access must be even; a simultaneous load and store is malformed.
   function automatic logic access_fault(input logic [ADDR_W-1:0] a,
                                         input logic rd,
                                         input logic wr);
      return a[0] | (rd & wr);
   endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating BUSY-cycle counter; term_o flags the last permitted wait cycle.
module mem_timeout_cnt
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic term_o
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SAT  = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, otherwise count up and stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i && (cnt_q != SAT)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: stalls the pipeline around a multi-cycle data memory
// access, releases one advance cycle on completion and latches sticky faults.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_mem,
   input  logic              write_mem,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              pipe_en,
   output logic [DATA_W-1:0] rdata_out,
   output logic              rdata_valid,
   output logic              err
);

   state_e            state_q, state_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic cnt_clr_s;
   logic cnt_en_s;
   logic cnt_term_s;
   logic pipe_en_s;
   logic mem_en_s;
   logic rdata_valid_s;
   logic err_s;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (cnt_clr_s),
      .en_i   (cnt_en_s),
      .term_o (cnt_term_s)
   );

   // Next-state, capture and output decode.
   always_comb begin
      state_d       = state_q;
      mem_wr_d      = mem_wr_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      cnt_clr_s     = 1'b0;
      cnt_en_s      = 1'b0;
      pipe_en_s     = 1'b0;
      mem_en_s      = 1'b0;
      rdata_valid_s = 1'b0;
      err_s         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (read_mem || write_mem) begin
               if (access_fault(addr, read_mem, write_mem)) begin
                  state_d = ST_ERR;
               end else begin
                  state_d   = ST_BUSY;
                  mem_wr_d  = write_mem;
                  addr_d    = addr;
                  wdata_d   = wdata;
                  cnt_clr_s = 1'b1;
               end
            end else begin
               pipe_en_s = 1'b1;
            end
         end
         ST_BUSY: begin
            mem_en_s = 1'b1;
            cnt_en_s = 1'b1;
            // Completion beats a timeout landing on the same cycle.
            if (mem_done) begin
               state_d = ST_DONE;
               if (!mem_wr_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (cnt_term_s) begin
               state_d = ST_ERR;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            pipe_en_s     = 1'b1;
            rdata_valid_s = ~mem_wr_q;
            state_d       = ST_IDLE;
         end
         ST_ERR: begin
            err_s   = 1'b1;
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured-access registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         mem_wr_q <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         wdata_q  <= {DATA_W{1'b0}};
         rdata_q  <= {DATA_W{1'b0}};
      end else begin
         state_q  <= state_d;
         mem_wr_q <= mem_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
      end
   end

   assign mem_en      = mem_en_s;
   assign mem_wr      = mem_wr_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign pipe_en     = pipe_en_s;
   assign rdata_out   = rdata_q;
   assign rdata_valid = rdata_valid_s;
   assign err         = err_s;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_mem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        read_mem = 1'b0;
   logic        write_mem = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic        mem_done = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_en, mem_wr, pipe_en, rdata_valid, err;
   logic [15:0] mem_addr, mem_wdata, rdata_out;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .read_mem   (read_mem),
      .write_mem  (write_mem),
      .addr       (addr),
      .wdata      (wdata),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_done   (mem_done),
      .mem_rdata  (mem_rdata),
      .pipe_en    (pipe_en),
      .rdata_out  (rdata_out),
      .rdata_valid(rdata_valid),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkn(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: an access is outstanding, an advance is owed, or a fault is latched.
   bit          m_pend, m_adv, m_flt, m_load, m_wr;
   int          m_wait;
   logic [15:0] m_addr, m_wd, m_rd;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_pend = 1'b0; m_adv = 1'b0; m_flt = 1'b0; m_load = 1'b0; m_wr = 1'b0;
            m_wait = 0; m_addr = 16'h0000; m_wd = 16'h0000; m_rd = 16'h0000;
         end
         chk1("model_pipe_en", pipe_en,
              m_adv ? 1'b1 : ((m_pend || m_flt) ? 1'b0 : !(read_mem || write_mem)));
         chk1("model_mem_en", mem_en, m_pend);
         chk1("model_err", err, m_flt);
         chk1("model_rdata_valid", rdata_valid, m_adv && m_load);
         chk16("model_rdata_out", rdata_out, m_rd);
         chk1("model_mem_wr", mem_wr, m_wr);
         chk16("model_mem_addr", mem_addr, m_addr);
         chk16("model_mem_wdata", mem_wdata, m_wd);
         if (rst) begin
            if (m_flt) begin
               m_flt = 1'b1;
            end else if (m_adv) begin
               m_adv = 1'b0;
            end else if (m_pend) begin
               m_wait++;
               if (mem_done) begin
                  m_pend = 1'b0;
                  m_adv  = 1'b1;
                  if (m_load) m_rd = mem_rdata;
               end else if (m_wait == TO) begin
                  m_pend = 1'b0;
                  m_flt  = 1'b1;
               end
            end else if (read_mem || write_mem) begin
               if ((read_mem && write_mem) || addr[0]) begin
                  m_flt = 1'b1;
               end else begin
                  m_pend = 1'b1; m_wait = 0; m_load = read_mem; m_wr = write_mem;
                  m_addr = addr; m_wd = wdata;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      read_mem = 1'b0; write_mem = 1'b0; mem_done = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // Present one op in EX/MEM and hold it until the advance cycle (bounded).
   task automatic mem_op(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] wd, input int done_at, input logic [15:0] rdv,
                         input int max_cyc, output int lows, output int vals, output int mens,
                         output logic fwr, output logic [15:0] faddr, output logic [15:0] fwd);
      bit adv;
      bit got;
      lows = 0; vals = 0; mens = 0; got = 1'b0;
      fwr = 1'b0; faddr = 16'h0000; fwd = 16'h0000;
      read_mem = r; write_mem = w; addr = a; wdata = wd; mem_rdata = rdv;
      for (int c = 0; c < max_cyc; c++) begin
         mem_done = (done_at != 0) && (c == done_at);
         @(negedge clk);
         if (!pipe_en) lows++;
         if (rdata_valid) vals++;
         if (mem_en) mens++;
         if (mem_en && !got) begin
            got = 1'b1; fwr = mem_wr; faddr = mem_addr; fwd = mem_wdata;
         end
         adv = pipe_en && (c > 0);
         step();
         if (adv) break;
      end
      read_mem = 1'b0; write_mem = 1'b0; mem_done = 1'b0;
   endtask

   int          lows, vals, mens;
   logic        fwr;
   logic [15:0] faddr, fwd;

   initial begin
      do_reset();
      @(negedge clk);
      chk1("reset_pipe_en", pipe_en, 1'b1);
      chk1("reset_mem_en", mem_en, 1'b0);
      chk1("reset_err", err, 1'b0);
      chk16("reset_rdata_out", rdata_out, 16'h0000);
      chk16("reset_mem_addr", mem_addr, 16'h0000);
      step();

      // Non-memory cycles with a stray completion pulse that must be ignored.
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      step();

      mem_op(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 10, lows, vals, mens, fwr, faddr, fwd);
      chkn("load_stall_cycles", lows, 3);
      chkn("load_valid_count", vals, 1);
      chkn("load_mem_en_cycles", mens, 2);
      chk16("load_rdata_out", rdata_out, 16'hBEEF);

      mem_op(1'b0, 1'b1, 16'h0020, 16'h1234, 1, 16'h5555, 10, lows, vals, mens, fwr, faddr, fwd);
      chkn("store_valid_count", vals, 0);
      chkn("store_stall_cycles", lows, 2);
      chk1("store_mem_wr", fwr, 1'b1);
      chk16("store_mem_addr", faddr, 16'h0020);
      chk16("store_mem_wdata", fwd, 16'h1234);
      chk16("store_rdata_kept", rdata_out, 16'hBEEF);

      mem_op(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h0A0A, 10, lows, vals, mens, fwr, faddr, fwd);
      mem_op(1'b1, 1'b0, 16'h0102, 16'h0000, 3, 16'hC3C3, 10, lows, vals, mens, fwr, faddr, fwd);
      chkn("b2b_second_stall", lows, 4);
      chk16("b2b_rdata_out", rdata_out, 16'hC3C3);

      mem_op(1'b1, 1'b0, 16'h0030, 16'h0000, TO, 16'h7777, 10, lows, vals, mens, fwr, faddr, fwd);
      chkn("late_done_mem_en", mens, 4);
      chkn("late_done_stall", lows, 5);
      chk1("late_done_err", err, 1'b0);
      chk16("late_done_rdata", rdata_out, 16'h7777);

      mem_op(1'b1, 1'b0, 16'h0011, 16'h0000, 0, 16'h0000, 21, lows, vals, mens, fwr, faddr, fwd);
      chkn("unaligned_mem_en", mens, 0);
      chkn("unaligned_stall", lows, 21);
      chk1("unaligned_err", err, 1'b1);
      do_reset();

      mem_op(1'b1, 1'b1, 16'h0040, 16'h0000, 0, 16'h0000, 5, lows, vals, mens, fwr, faddr, fwd);
      chkn("rdwr_mem_en", mens, 0);
      chk1("rdwr_err", err, 1'b1);
      do_reset();

      mem_op(1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'h0000, 10, lows, vals, mens, fwr, faddr, fwd);
      chkn("timeout_mem_en", mens, TO);
      chkn("timeout_stall", lows, 10);
      chk1("timeout_err", err, 1'b1);
      chk1("timeout_mem_en_low", mem_en, 1'b0);
      chk1("timeout_pipe_en_low", pipe_en, 1'b0);
      do_reset();

      // Asynchronous reset on the second BUSY cycle.
      read_mem = 1'b1; addr = 16'h0060;
      step();
      step();
      chk1("midbusy_mem_en_before", mem_en, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk1("midbusy_mem_en_async", mem_en, 1'b0);
      read_mem = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk1("post_reset_pipe_en", pipe_en, 1'b1);
      chk1("post_reset_mem_wr", mem_wr, 1'b0);
      chk16("post_reset_mem_addr", mem_addr, 16'h0000);
      chk16("post_reset_rdata", rdata_out, 16'h0000);
      step();

      mem_op(1'b1, 1'b0, 16'h0070, 16'h0000, 1, 16'h1357, 10, lows, vals, mens, fwr, faddr, fwd);
      chkn("final_load_valid", vals, 1);
      chk16("final_load_rdata", rdata_out, 16'h1357);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
